// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Multiplexes a single data-memory BRAM port between the core load/store path
// and buffered I/O receive-data writes. I/O writes sit in a small FIFO and are
// drained into cycles the core leaves idle. The core normally wins, but a
// starvation counter and a FIFO-full override bound how long I/O data waits.
module dmem_port_arbiter #(
    parameter int ACTUAL_ADDR_W = 32,
    parameter int WORD_W        = 32,
    parameter int IO_FIFO_DEPTH = 4,   // power of two, >= 2
    parameter int STARVE_LIMIT  = 8    // >= 1
) (
    input  logic                               clk,
    input  logic                               rst,

    // core load/store path
    input  logic                               core_req,
    input  logic                               core_we,
    input  logic [ACTUAL_ADDR_W-1:0]           core_addr,
    input  logic [WORD_W-1:0]                  core_wdata,
    output logic                               core_gnt,
    output logic                               core_rvalid,
    output logic [WORD_W-1:0]                  core_rdata,

    // I/O controller write path
    input  logic                               io_we,
    input  logic [ACTUAL_ADDR_W-1:0]           io_addr,
    input  logic [WORD_W-1:0]                  io_wdata,
    output logic                               io_full,
    output logic [$clog2(IO_FIFO_DEPTH):0]     io_count,
    output logic                               io_overflow,

    // BRAM port
    output logic [ACTUAL_ADDR_W-1:0]           bram_addr,
    output logic [WORD_W-1:0]                  bram_wrdata,
    output logic                               bram_we,
    output logic                               bram_en,
    input  logic [WORD_W-1:0]                  bram_rddata
);

    localparam int PTR_W    = $clog2(IO_FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]    DEPTH_CNT  = CNT_W'(IO_FIFO_DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]         wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]         count_q,      count_d;
    logic [STARVE_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                     rvalid_q,     rvalid_d;
    logic                     overflow_q,   overflow_d;

    // FIFO storage: one address/data pair per entry
    logic [ACTUAL_ADDR_W-1:0] entry_addr_q [IO_FIFO_DEPTH];
    logic [WORD_W-1:0]        entry_data_q [IO_FIFO_DEPTH];
    logic [IO_FIFO_DEPTH-1:0] entry_we;

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     starve_at_limit;
    logic                     io_win;
    logic                     core_win;
    logic                     push;
    logic                     pop;
    logic [ACTUAL_ADDR_W-1:0] head_addr;
    logic [WORD_W-1:0]        head_data;

    assign fifo_empty      = (count_q == '0);
    assign fifo_full       = (count_q == DEPTH_CNT);
    assign starve_at_limit = (starve_cnt_q == STARVE_MAX);

    // The head entry must be presented in the same cycle the I/O side wins,
    // so the FIFO is read asynchronously (small distributed storage).
    assign head_addr = entry_addr_q[rd_ptr_q];
    assign head_data = entry_data_q[rd_ptr_q];

    // I/O takes the port whenever the core is idle, has hogged it for
    // STARVE_LIMIT cycles, or the FIFO can no longer accept data.
    assign io_win = !fifo_empty && (!core_req || starve_at_limit || fifo_full);

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push = io_we && !fifo_full && !rst;

    // Per-entry write enables for the FIFO storage
    generate
        for (genvar gi = 0; gi < IO_FIFO_DEPTH; gi++) begin : g_entry
            assign entry_we[gi] = push && (wr_ptr_q == PTR_W'(gi));

            // Capture an I/O write into this slot when it is the tail
            always_ff @(posedge clk) begin
                if (entry_we[gi]) begin
                    entry_addr_q[gi] <= io_addr;
                    entry_data_q[gi] <= io_wdata;
                end
            end
        end
    endgenerate

    // Port mux: choose the winner and drive the BRAM; nothing is issued in reset
    always_comb begin
        core_gnt    = 1'b0;
        core_win    = 1'b0;
        pop         = 1'b0;
        bram_en     = 1'b0;
        bram_we     = 1'b0;
        bram_addr   = core_addr;
        bram_wrdata = core_wdata;
        if (!rst) begin
            if (io_win) begin
                pop         = 1'b1;
                bram_en     = 1'b1;
                bram_we     = 1'b1;
                bram_addr   = head_addr;
                bram_wrdata = head_data;
            end else if (core_req) begin
                core_win = 1'b1;
                core_gnt = 1'b1;
                bram_en  = 1'b1;
                bram_we  = core_we;
            end
        end
    end

    // Next-state: FIFO pointers/occupancy, starvation counter, load response, overflow
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_cnt_d = '0;
        rvalid_d     = core_win && !core_we;
        overflow_d   = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Count only cycles where the core wins while I/O data is waiting
        if (core_win && !fifo_empty) begin
            if (starve_at_limit) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end
        end

        if (io_we && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            rvalid_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            rvalid_q     <= rvalid_d;
            overflow_q   <= overflow_d;
        end
    end

    // A load response pending across a reset edge must not leak out during reset
    assign core_rvalid = rvalid_q && !rst;
    assign core_rdata  = bram_rddata;

    assign io_full     = fifo_full;
    assign io_count    = count_q;
    assign io_overflow = overflow_q;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares one data-memory BRAM port between the core's load/store path and the I/O controller's receive-data writes, so AXI input no longer needs a dedicated BRAM port. I/O writes are buffered in a small FIFO and drained into idle memory cycles. The core normally has priority. A starvation limit and a FIFO-full override guarantee that I/O data always lands in memory. The block sits between `core`/`io_controller` and the BRAM.

## Interface
Parameters:
- `ACTUAL_ADDR_W`, 32, BRAM address width
- `WORD_W`, 32, data width
- `IO_FIFO_DEPTH`, 4, I/O write FIFO entries; must be a power of two and at least 2
- `STARVE_LIMIT`, 8, maximum consecutive cycles the core may win while the FIFO is non-empty; must be at least 1

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `core_req`  in  1  core requests an access
- `core_we`  in  1  1 = store, 0 = load
- `core_addr`  in  ACTUAL_ADDR_W  core address
- `core_wdata`  in  WORD_W  store data
- `core_gnt`  out  1  access issued to BRAM this cycle (combinational)
- `core_rvalid`  out  1  load data valid
- `core_rdata`  out  WORD_W  load data
- `io_we`  in  1  push an I/O write
- `io_addr`  in  ACTUAL_ADDR_W  I/O write address
- `io_wdata`  in  WORD_W  I/O write data
- `io_full`  out  1  FIFO holds IO_FIFO_DEPTH entries
- `io_count`  out  clog2(IO_FIFO_DEPTH)+1  FIFO occupancy
- `io_overflow`  out  1  sticky flag: a push was dropped
- `bram_addr`  out  ACTUAL_ADDR_W  BRAM address
- `bram_wrdata`  out  WORD_W  BRAM write data
- `bram_we`  out  1  BRAM write enable
- `bram_en`  out  1  BRAM enable
- `bram_rddata`  in  WORD_W  BRAM read data, valid 1 cycle after address

## Operation
- At most one access per cycle. Grant is decided combinationally from `core_req`, FIFO state and `starve_cnt`.
- **io wins** when:
  - the FIFO is non-empty AND (`core_req`=0 OR `starve_cnt`==STARVE_LIMIT OR `io_full`=1).
  - Action: issue the head entry (`bram_we`=1, `bram_en`=1, head address and data), pop it, clear `starve_cnt`.
- **core wins** when `core_req`=1 and io does not win.
  - Action: `core_gnt`=1, `bram_en`=1, `bram_we`=`core_we`, core address and data driven.
  - `starve_cnt` increments (saturating at STARVE_LIMIT) if the FIFO is non-empty; otherwise it clears.
- **Idle**: `bram_en`=0, `bram_we`=0, `core_gnt`=0, `starve_cnt`=0.
- **Core handshake**: the core holds `core_req`, `core_addr`, `core_we` and `core_wdata` stable until the cycle with `core_gnt`=1.
- **Push**: `io_we`=1 with `io_full`=0 enqueues at the tail.
  - With `io_full`=1 the push is dropped and `io_overflow` is set. This holds even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full FIFO keeps `io_count` unchanged.
- A pushed entry is poppable from the next cycle.
- Read and write pointers wrap modulo IO_FIFO_DEPTH.
- No forwarding between the FIFO and core loads. Software ordering via the consumer pointer protocol covers coherence.
- `io_overflow` clears only on reset.

## Timing
- Core access: `core_gnt` is asserted in the same cycle as `core_req` when the core wins.
- Core load latency: `core_rvalid`=1 exactly 1 cycle after a granted load. `core_rdata`=`bram_rddata` in that cycle. No rvalid after a granted store.
- I/O latency: an entry pushed in cycle t is written no earlier than t+1. Under continuous core requests it is written no later than t+1+STARVE_LIMIT.
- During reset (`rst`=1) no access is issued: `bram_en`=0, `bram_we`=0, `core_gnt`=0.
- Registered state after the reset edge:
  - FIFO empty; `io_count`=0 and `io_full`=0
  - `starve_cnt`=0
  - `core_rvalid`=0
  - `io_overflow`=0
- Reset mid-operation discards all FIFO contents and any pending load response.

## Test plan
- **Core load**: BRAM[5]=0xDEADBEEF; `core_req`=1, `core_we`=0, `core_addr`=5 in cycle 0 → `core_gnt`=1 and `bram_addr`=5 in cycle 0; `core_rvalid`=1 and `core_rdata`=0xDEADBEEF in cycle 1.
- **Idle drain**: core idle; push (10,0xA), (11,0xB), (12,0xC) in cycles 0–2 → BRAM writes at addresses 10, 11, 12 in cycles 1–3; `io_count` returns to 0 in cycle 4.
- **Starvation bound**: STARVE_LIMIT=8; `core_req` held at 1 continuously; one push in cycle 0 → core granted in cycles 1–8; io write with `core_gnt`=0 in cycle 9; core granted again from cycle 10.
- **Full/overflow**: DEPTH=4; `core_req` held at 1; push 4 entries → `io_full`=1 and io wins every following cycle until not full. A 5th push while full → dropped, `io_overflow`=1, and only 4 BRAM writes occur.
- **Simultaneous push/pop**: `io_count`=1, core idle, push in the same cycle the head pops → `io_count` stays 1 and the new entry is written next cycle.
- **Reset mid-operation**: `io_count`=2 and a load granted the previous cycle; assert `rst` for 1 cycle → no BRAM write and `core_rvalid`=0 in the reset cycle; afterwards `io_count`=0 and no stale writes occur.
